fp_div: RTL

Sequential signed fixed-point divider, the inverse of the team's `fp_mult`.
- Computes quotient = in1 / in2 for Q(WI1.WF1) / Q(WI2.WF2) operands.
- Uses a restoring shift-subtract loop that produces one quotient bit per clock.
- Result is truncated toward zero and saturated into Q(WIO.WFO).
- Used by the cosine-approximation datapath for normalization and reciprocal terms.
- Valid/ready handshakes on both sides.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_div_core.sv | 22 ++
 rtl/fp_div.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared constants for the fixed-point arithmetic blocks.
package fp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Largest positive two's-complement value of a w-bit word.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Bit pattern (and magnitude) of the most negative w-bit value.
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fp_div_core.sv
// One restoring-division step: shift in a numerator bit, compare, subtract.
module fp_div_core #(
  parameter int W2 = 20
) (
  input  logic [W2:0]   rem_i,
  input  logic          num_msb_i,
  input  logic [W2-1:0] div_i,
  output logic [W2:0]   rem_o,
  output logic          q_o
);

  logic [W2:0] shifted;

  // The remainder stays below the divisor, so its top bit is normally zero;
  // folding it into the compare keeps the step correct even if it were set.
  always_comb begin
    shifted = {rem_i[W2-1:0], num_msb_i};
    q_o     = rem_i[W2] | (shifted >= {1'b0, div_i});
    rem_o   = q_o ? (shifted - {1'b0, div_i}) : shifted;
  end

endmodule

// File: rtl/fp_div.sv
// Sequential signed fixed-point divider: one quotient bit per clock,
// truncation toward zero and saturation into the output format.
module fp_div
  import fp_pkg::*;
#(
  parameter int WI1 = 4,
  parameter int WF1 = 16,
  parameter int WI2 = 4,
  parameter int WF2 = 16,
  parameter int WIO = 8,
  parameter int WFO = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI1+WF1-1:0]   in1,
  input  logic [WI2+WF2-1:0]   in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   out,
  output logic                 ovf,
  output logic                 dz
);

  localparam int W1 = WI1 + WF1;
  localparam int W2 = WI2 + WF2;
  localparam int SH = WFO + WF2 - WF1;
  localparam int NB = W1 + SH;
  localparam int WO = WIO + WFO;
  localparam int CW = $clog2(NB + 1);

  localparam logic [WO-1:0] MAX_V   = WO'(sat_max(WO));
  localparam logic [WO-1:0] MIN_V   = WO'(sat_min(WO));
  localparam logic [NB-1:0] MAX_Q   = NB'(sat_max(WO));
  localparam logic [NB-1:0] MINMAG_Q = NB'(sat_min(WO));

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic          sign1_q, sign1_d;
  logic          dzl_q, dzl_d;
  logic [NB-1:0] num_q, num_d;
  logic [W2-1:0] div_q, div_d;
  logic [W2:0]   rem_q, rem_d;
  logic [NB-1:0] quo_q, quo_d;
  logic [WO-1:0] out_q, out_d;
  logic          ovf_q, ovf_d;
  logic          dz_q, dz_d;

  logic [W1-1:0] mag1;
  logic [W2-1:0] mag2;
  logic [NB-1:0] quo_neg;
  logic [W2:0]   rem_nxt;
  logic          qbit;

  fp_div_core #(.W2(W2)) u_core (
    .rem_i     (rem_q),
    .num_msb_i (num_q[NB-1]),
    .div_i     (div_q),
    .rem_o     (rem_nxt),
    .q_o       (qbit)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

  // Operand magnitudes are unsigned so the most negative input is exact.
  always_comb begin
    mag1    = in1[W1-1] ? (~in1 + W1'(1)) : in1;
    mag2    = in2[W2-1] ? (~in2 + W2'(1)) : in2;
    quo_neg = ~quo_q + NB'(1);
  end

  // Next-state: accept, iterate, saturate, hold until handed off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    sign1_d = sign1_q;
    dzl_d   = dzl_q;
    num_d   = num_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = in1[W1-1] ^ in2[W2-1];
          sign1_d = in1[W1-1];
          num_d   = NB'(mag1) << SH;
          div_d   = mag2;
          dzl_d   = (in2 == '0);
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(NB);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        rem_d = rem_nxt;
        quo_d = {quo_q[NB-2:0], qbit};
        num_d = num_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        dz_d = dzl_q;
        if (dzl_q) begin
          out_d = sign1_q ? MIN_V : MAX_V;
          ovf_d = 1'b0;
        end else if (!sign_q && (quo_q > MAX_Q)) begin
          out_d = MAX_V;
          ovf_d = 1'b1;
        end else if (sign_q && (quo_q > MINMAG_Q)) begin
          out_d = MIN_V;
          ovf_d = 1'b1;
        end else begin
          out_d = sign_q ? quo_neg[WO-1:0] : quo_q[WO-1:0];
          ovf_d = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      sign1_q <= 1'b0;
      dzl_q   <= 1'b0;
      num_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      sign1_q <= sign1_d;
      dzl_q   <= dzl_d;
      num_q   <= num_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

endmodule
